// File: rtl/dff_16bit_pkg.sv
// Shared datapath constants and the word type for the 16-bit RISC storage elements.
package dff_16bit_pkg;

  localparam int XLEN = 16;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t RESET_VALUE = 16'h0000;

endpackage : dff_16bit_pkg

// File: rtl/dff_16bit_bit.sv
// Single-bit flip-flop with write enable and synchronous active-high reset.
module dff_1bit #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic WE,
  input  logic D,
  output logic Q
);

  logic r_q;

  // Reset outranks the write enable; otherwise the bit holds.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q <= RST_VAL;
    end else if (WE) begin
      r_q <= D;
    end else begin
      r_q <= r_q;
    end
  end

  assign Q = r_q;

endmodule : dff_1bit

// File: rtl/dff_16bit.sv
// Word-wide enabled register built from one dff_1bit per bit, sharing clock, reset and enable.
module dff_16bit
  import dff_16bit_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             WE,
  output logic [WIDTH-1:0] Q
);

  // Reset word resized so non-default widths still reset to the package value.
  localparam logic [WIDTH-1:0] RST_WORD = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] w_q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    dff_1bit #(
      .RST_VAL (RST_WORD[gi])
    ) u_bit (
      .CLK (CLK),
      .RST (RST),
      .WE  (WE),
      .D   (D[gi]),
      .Q   (w_q[gi])
    );
  end

  assign Q = w_q;

endmodule : dff_16bit

// File: tb/tb_dff_16bit.sv
// Directed, table-driven bench for dff_16bit: inputs change on the falling edge, Q is sampled 1 ns after the rising edge.
module tb_dff_16bit;
  import dff_16bit_pkg::*;

  typedef struct {
    logic  rst;
    logic  we;
    word_t d;
    word_t exp_q;
  } vec_t;

  logic  CLK;
  logic  RST;
  logic  WE;
  word_t D;
  word_t Q;

  int n_checks;
  int n_fail;

  vec_t vecs[$];

  dff_16bit #(.WIDTH(XLEN)) dut (
    .CLK (CLK),
    .RST (RST),
    .D   (D),
    .WE  (WE),
    .Q   (Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: Q=%h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input word_t d);
    @(negedge CLK);
    RST = rst;
    WE  = we;
    D   = d;
  endtask

  task automatic edge_check(input string name, input word_t exp);
    @(posedge CLK);
    #1;
    check(name, Q, exp);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST = 1'b0;
    WE  = 1'b0;
    D   = 16'h0000;

    // Power-up hold: no reset, no write -> Q stays X.
    edge_check("powerup_hold_0", 16'hxxxx);
    edge_check("powerup_hold_1", 16'hxxxx);

    // Write, overwrite, then hold with WE low.
    vecs.push_back('{1'b0, 1'b1, 16'h0625, 16'h0625});
    vecs.push_back('{1'b0, 1'b1, 16'h00CB, 16'h00CB});
    vecs.push_back('{1'b0, 1'b0, 16'hFFFF, 16'h00CB});
    vecs.push_back('{1'b0, 1'b0, 16'hFFFF, 16'h00CB});
    vecs.push_back('{1'b0, 1'b0, 16'hFFFF, 16'h00CB});
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].d);
      edge_check($sformatf("vec_%0d", i), vecs[i].exp_q);
    end

    // Synchronous reset: no effect before the edge, zero after it.
    drive(1'b1, 1'b0, 16'hFFFF);
    #1;
    check("reset_before_edge", Q, 16'h00CB);
    edge_check("reset_after_edge", 16'h0000);

    // Reset priority over WE, then write resumes.
    vecs.delete();
    vecs.push_back('{1'b1, 1'b1, 16'hA5A5, 16'h0000});
    vecs.push_back('{1'b0, 1'b1, 16'hA5A5, 16'hA5A5});
    // Reset inside a write burst, then writes resume.
    vecs.push_back('{1'b0, 1'b1, 16'h1234, 16'h1234});
    vecs.push_back('{1'b1, 1'b1, 16'h5678, 16'h0000});
    vecs.push_back('{1'b0, 1'b1, 16'h5678, 16'h5678});
    // Walking one, back-to-back writes.
    for (int b = 0; b < XLEN; b++) begin
      word_t w;
      w = word_t'(1) << b;
      vecs.push_back('{1'b0, 1'b1, w, w});
    end
    vecs.push_back('{1'b0, 1'b1, 16'h5AC3, 16'h5AC3});
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].d);
      edge_check($sformatf("vec2_%0d", i), vecs[i].exp_q);
    end

    // Mid-cycle D/WE glitches have no effect; only values at the edge count.
    drive(1'b0, 1'b0, 16'h0F0F);
    #2;
    WE = 1'b1;
    #1;
    check("no_comb_path", Q, 16'h5AC3);
    WE = 1'b0;
    D  = 16'hF0F0;
    edge_check("midcycle_we_ignored", 16'h5AC3);
    drive(1'b0, 1'b1, 16'h3C3C);
    #2;
    D = 16'hC3C3;
    edge_check("edge_value_captured", 16'hC3C3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_dff_16bit
